// File: rtl/crane_round_ctrl_if.sv
// Signal bundle between the crane round sequencer and its neighbours:
// debounced front-panel inputs, countdown timer, claw motion block and display.
interface crane_round_ctrl_if;
  // Inputs to the sequencer
  logic        coin;
  logic        grab_btn;
  logic [15:0] timer_count;
  logic        claw_done;
  logic        prize_detect;

  // Outputs from the sequencer
  logic        timer_reset;
  logic        claw_enable;
  logic        grab_start;
  logic        win;
  logic [3:0]  credits;
  logic [7:0]  prize_count;
  logic [2:0]  state;

  // Surroundings: drive the panel, timer and claw signals, observe the sequencer
  modport master (
    output coin, grab_btn, timer_count, claw_done, prize_detect,
    input  timer_reset, claw_enable, grab_start, win, credits, prize_count, state
  );

  // The sequencer itself
  modport slave (
    input  coin, grab_btn, timer_count, claw_done, prize_detect,
    output timer_reset, claw_enable, grab_start, win, credits, prize_count, state
  );
endinterface

// File: rtl/crane_round_ctrl.sv
// Crane game round sequencer: takes coin credits, starts a round on the
// player's button, reloads the countdown timer, enables the claw while time
// remains, issues the grab, scores the result and holds it for display.
module crane_round_ctrl #(
  parameter int unsigned MAX_CREDITS   = 9,
  parameter int unsigned RESULT_CYCLES = 200000000
) (
  input logic               clock_100Mhz,
  input logic               reset,
  crane_round_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_PLAY   = 3'd2;
  localparam logic [2:0] S_GRAB   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  localparam logic [3:0]  CREDIT_MAX  = 4'(MAX_CREDITS);
  localparam logic [27:0] RESULT_LAST = 28'(RESULT_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic        coin_prev;
  logic        grab_prev;
  logic        coin_edge;
  logic        grab_edge;
  logic        start;
  logic        play_exit;
  logic [3:0]  credits;
  logic [4:0]  credits_sum;
  logic [3:0]  credits_next;
  logic [7:0]  prize_count;
  logic        win;
  logic        claw_enable;
  logic        grab_start;
  logic [27:0] result_cnt;

  // Rising-edge detection; prev registers come out of reset high so that a
  // level held through reset release is not mistaken for a fresh press.
  assign coin_edge = bus.coin & ~coin_prev;
  assign grab_edge = bus.grab_btn & ~grab_prev;

  // A round starts only from IDLE with at least one credit available.
  assign start     = (state == S_IDLE) && grab_edge && (credits != 4'd0);
  // Button press and timeout in the same cycle collapse to one exit.
  assign play_exit = (state == S_PLAY) && (grab_edge || (bus.timer_count == 16'd0));

  // start implies credits > 0, so the sum never underflows; one extra bit
  // holds the overflow before clamping.
  assign credits_sum  = {1'b0, credits} + {4'd0, coin_edge} - {4'd0, start};
  assign credits_next = (credits_sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : credits_sum[3:0];

  // Next-state decode; unused encodings fall back to IDLE.
  always_comb begin
    // NOTE: default assignment first so every path drives state_next and no latch is inferred.
    state_next = state;
    case (state)
      S_IDLE:   if (start)                    state_next = S_ARM;
      S_ARM:                                  state_next = S_PLAY;
      S_PLAY:   if (play_exit)                state_next = S_GRAB;
      S_GRAB:   if (bus.claw_done)            state_next = S_RESULT;
      S_RESULT: if (result_cnt == RESULT_LAST) state_next = S_IDLE;
      default:                                state_next = S_IDLE;
    endcase
  end

  // State, credits, scoring and registered claw outputs.
  always_ff @(posedge clock_100Mhz) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= S_IDLE;
      coin_prev   <= 1'b1;
      grab_prev   <= 1'b1;
      credits     <= 4'd0;
      prize_count <= 8'd0;
      win         <= 1'b0;
      claw_enable <= 1'b0;
      grab_start  <= 1'b0;
      result_cnt  <= 28'd0;
    end else begin
      state       <= state_next;
      coin_prev   <= bus.coin;
      grab_prev   <= bus.grab_btn;
      credits     <= credits_next;
      claw_enable <= (state_next == S_PLAY);
      grab_start  <= play_exit;

      // Counter idles at zero outside RESULT, so it is already cleared on entry.
      if (state == S_RESULT) result_cnt <= result_cnt + 28'd1;
      else                   result_cnt <= 28'd0;

      // Score on the cycle the claw reports completion.
      if ((state == S_GRAB) && bus.claw_done) begin
        win <= bus.prize_detect;
        if (bus.prize_detect && (prize_count != 8'hFF)) prize_count <= prize_count + 8'd1;
      end
    end
  end

  // Timer reload is decoded from the state register, so it lasts exactly the ARM cycle.
  assign bus.timer_reset = reset | (state == S_ARM);
  assign bus.claw_enable = claw_enable;
  assign bus.grab_start  = grab_start;
  assign bus.win         = win;
  assign bus.credits     = credits;
  assign bus.prize_count = prize_count;
  assign bus.state       = state;

endmodule

// File: tb/tb_crane_round_ctrl.sv
// Self-checking bench for crane_round_ctrl: expected values are queued when
// stimulus is driven and compared against DUT samples taken 1 ns after the
// rising edge.
module tb_crane_round_ctrl;

  localparam int unsigned MAX_CREDITS   = 9;
  localparam int unsigned RESULT_CYCLES = 4;

  localparam logic [31:0] IDLE   = 32'd0;
  localparam logic [31:0] ARM    = 32'd1;
  localparam logic [31:0] PLAY   = 32'd2;
  localparam logic [31:0] GRAB   = 32'd3;
  localparam logic [31:0] RESULT = 32'd4;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  logic clock_100Mhz = 1'b0;
  logic reset;

  crane_round_ctrl_if bus();

  crane_round_ctrl #(
    .MAX_CREDITS  (MAX_CREDITS),
    .RESULT_CYCLES(RESULT_CYCLES)
  ) dut (
    .clock_100Mhz(clock_100Mhz),
    .reset       (reset),
    .bus         (bus)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  exp_t        exp_q[$];
  logic [31:0] obs_q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned model_credits = 0;
  int unsigned model_prizes  = 0;

  task automatic step();
    @(posedge clock_100Mhz);
    #1;
  endtask

  task automatic want(input string name, input logic [31:0] value);
    exp_t e;
    e.name  = name;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic sample(input logic [31:0] value);
    obs_q.push_back(value);
  endtask

  task automatic pulse_coin();
    bus.coin = 1'b1;
    model_credits = (model_credits + 1 > MAX_CREDITS) ? MAX_CREDITS : model_credits + 1;
    step();
    bus.coin = 1'b0;
    step();
  endtask

  // Reset values, timer reload held during reset, release.
  task automatic test_reset();
    exp_t e; logic [31:0] o;
    reset = 1'b1;
    bus.coin = 1'b0; bus.grab_btn = 1'b0; bus.claw_done = 1'b0;
    bus.prize_detect = 1'b0; bus.timer_count = 16'd30;
    model_credits = 0; model_prizes = 0;
    want("reset state", IDLE); want("reset credits", 0); want("reset prize_count", 0);
    want("reset win", 0); want("reset claw_enable", 0); want("reset grab_start", 0);
    want("reset timer_reset", 1);
    step(); step();
    sample(bus.state); sample(bus.credits); sample(bus.prize_count);
    sample(bus.win); sample(bus.claw_enable); sample(bus.grab_start); sample(bus.timer_reset);
    reset = 1'b0;
    want("post-reset timer_reset", 0); want("post-reset state", IDLE);
    step();
    sample(bus.timer_reset); sample(bus.state);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x; checks++;
      if (o !== e.value) begin failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, o, e.value); end
    end
  endtask

  // Two coins, then a start: ARM with timer reload for one cycle, then PLAY.
  task automatic test_coin_start();
    exp_t e; logic [31:0] o;
    pulse_coin(); pulse_coin();
    want("two coins credits", model_credits);
    sample(bus.credits);
    bus.grab_btn = 1'b1;
    model_credits--;
    want("start state", ARM); want("start credits", model_credits);
    want("start timer_reset", 1); want("arm claw_enable", 0);
    step();
    sample(bus.state); sample(bus.credits); sample(bus.timer_reset); sample(bus.claw_enable);
    bus.grab_btn = 1'b0;
    want("arm->play state", PLAY); want("play timer_reset", 0); want("play claw_enable", 1);
    step();
    sample(bus.state); sample(bus.timer_reset); sample(bus.claw_enable);
    want("play holds", PLAY);
    step();
    sample(bus.state);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x; checks++;
      if (o !== e.value) begin failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, o, e.value); end
    end
  endtask

  // Timeout in PLAY gives a single grab_start pulse and enters GRAB.
  task automatic test_timeout();
    exp_t e; logic [31:0] o; int pulses;
    bus.timer_count = 16'd0;
    want("timeout state", GRAB); want("timeout grab_start", 1); want("grab claw_enable", 0);
    step();
    sample(bus.state); sample(bus.grab_start); sample(bus.claw_enable);
    pulses = int'(bus.grab_start);
    bus.timer_count = 16'd30;
    want("timeout pulse count", 1); want("grab waits for claw", GRAB);
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(bus.grab_start);
    end
    sample(pulses); sample(bus.state);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x; checks++;
      if (o !== e.value) begin failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, o, e.value); end
    end
  endtask

  // Claw completes: score, hold RESULT for RESULT_CYCLES, back to IDLE.
  // A grab press during RESULT must be ignored.
  task automatic test_result(input logic prize);
    exp_t e; logic [31:0] o; int n;
    bus.claw_done = 1'b1; bus.prize_detect = prize;
    if (prize && model_prizes < 255) model_prizes++;
    want("result entry state", RESULT); want("win latched", prize); want("prize_count", model_prizes);
    step();
    sample(bus.state); sample(bus.win); sample(bus.prize_count);
    bus.claw_done = 1'b0; bus.prize_detect = 1'b0;
    want("result length", RESULT_CYCLES); want("credits after result", model_credits);
    want("win held", prize); want("state after result", IDLE);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) bus.grab_btn = 1'b1;
      if (i == 2) bus.grab_btn = 1'b0;
      step();
      if (bus.state != RESULT[2:0]) break;
      n++;
    end
    sample(n); sample(bus.credits); sample(bus.win); sample(bus.state);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x; checks++;
      if (o !== e.value) begin failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, o, e.value); end
    end
  endtask

  // New round, then button and timeout together in PLAY: still one pulse.
  task automatic test_both_exit();
    exp_t e; logic [31:0] o; int pulses;
    bus.grab_btn = 1'b1;
    model_credits--;
    want("second start state", ARM); want("second start credits", model_credits);
    step();
    sample(bus.state); sample(bus.credits);
    bus.grab_btn = 1'b0;
    step(); step();
    bus.timer_count = 16'd0; bus.grab_btn = 1'b1;
    want("both exit state", GRAB); want("both exit grab_start", 1);
    step();
    sample(bus.state); sample(bus.grab_start);
    pulses = int'(bus.grab_start);
    bus.timer_count = 16'd30; bus.grab_btn = 1'b0;
    want("both exit pulse count", 1);
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(bus.grab_start);
    end
    sample(pulses);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x; checks++;
      if (o !== e.value) begin failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, o, e.value); end
    end
  endtask

  // No credit: grab ignored; coin and grab together give a credit, no start.
  task automatic test_no_credit();
    exp_t e; logic [31:0] o;
    bus.grab_btn = 1'b1;
    want("no-credit state", IDLE); want("no-credit timer_reset", 0); want("no-credit credits", 0);
    step();
    sample(bus.state); sample(bus.timer_reset); sample(bus.credits);
    bus.grab_btn = 1'b0;
    step();
    bus.coin = 1'b1; bus.grab_btn = 1'b1;
    model_credits = 1;
    want("coin+grab credits", model_credits); want("coin+grab state", IDLE);
    step();
    sample(bus.credits); sample(bus.state);
    bus.coin = 1'b0; bus.grab_btn = 1'b0;
    want("coin+grab no reload", 0); want("coin+grab stays idle", IDLE);
    step();
    sample(bus.timer_reset); sample(bus.state);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x; checks++;
      if (o !== e.value) begin failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, o, e.value); end
    end
  endtask

  // Twelve coins saturate at MAX; coin plus start at MAX stays at MAX.
  task automatic test_saturation();
    exp_t e; logic [31:0] o;
    for (int i = 0; i < 12; i++) pulse_coin();
    want("saturated credits", model_credits);
    sample(bus.credits);
    bus.coin = 1'b1; bus.grab_btn = 1'b1;
    want("max coin+start credits", model_credits); want("max coin+start state", ARM);
    step();
    sample(bus.credits); sample(bus.state);
    bus.coin = 1'b0; bus.grab_btn = 1'b0;
    want("max round plays", PLAY); want("max credits kept", model_credits);
    step();
    sample(bus.state); sample(bus.credits);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x; checks++;
      if (o !== e.value) begin failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, o, e.value); end
    end
  endtask

  // Reset during PLAY and during RESULT; levels held through release.
  task automatic test_reset_mid();
    exp_t e; logic [31:0] o;
    reset = 1'b1;
    model_credits = 0; model_prizes = 0;
    want("play reset state", IDLE); want("play reset credits", 0); want("play reset prizes", 0);
    want("play reset timer_reset", 1); want("play reset claw_enable", 0);
    step();
    sample(bus.state); sample(bus.credits); sample(bus.prize_count);
    sample(bus.timer_reset); sample(bus.claw_enable);
    reset = 1'b0;
    step();
    pulse_coin();
    bus.grab_btn = 1'b1; step(); bus.grab_btn = 1'b0; step();
    bus.timer_count = 16'd0; step(); bus.timer_count = 16'd30;
    bus.claw_done = 1'b1; bus.prize_detect = 1'b1;
    want("pre-reset result state", RESULT); want("pre-reset prize_count", 1);
    step();
    sample(bus.state); sample(bus.prize_count);
    bus.claw_done = 1'b0; bus.prize_detect = 1'b0;
    reset = 1'b1; bus.coin = 1'b1; bus.grab_btn = 1'b1;
    want("result reset state", IDLE); want("result reset prizes", 0);
    want("result reset win", 0); want("result reset credits", 0); want("result reset timer_reset", 1);
    step();
    sample(bus.state); sample(bus.prize_count); sample(bus.win);
    sample(bus.credits); sample(bus.timer_reset);
    reset = 1'b0;
    want("held levels no credit", 0); want("held levels stay idle", IDLE); want("held levels no reload", 0);
    step(); step();
    sample(bus.credits); sample(bus.state); sample(bus.timer_reset);
    bus.coin = 1'b0; bus.grab_btn = 1'b0;
    step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x; checks++;
      if (o !== e.value) begin failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, o, e.value); end
    end
  endtask

  initial begin
    test_reset();
    test_coin_start();
    test_timeout();
    test_result(1'b1);
    test_both_exit();
    test_result(1'b0);
    test_no_credit();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
